sign_converter_pipe: RTL and testbench
======================================

SIGN_CONVERTER_PIPE -- requirements
Module: sign_converter_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data width in bits, legal range 4..32.
REQ-002 SHALL have parameter OVF_CNT_W, default 16, overflow-counter width.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  input word present.
REQ-006 SHALL have port in_ready  output  1  block accepts input this cycle.
REQ-007 SHALL have port in_mode  input  2  conversion mode, sampled with in_data.
REQ-008 SHALL have port in_data  input  WIDTH  operand.
REQ-009 SHALL have port out_valid  output  1  result present.
REQ-010 SHALL have port out_ready  input  1  downstream accepts result.
REQ-011 SHALL have port out_data  output  WIDTH  result.
REQ-012 SHALL have port out_ovf  output  1  result saturated (not representable).
REQ-013 SHALL have port ovf_count  output  OVF_CNT_W  saturated-result count (present only with macro, REQ-031).

Function
REQ-014 SHALL implement modes: 00 pass-through; 01 two's-complement -> sign-magnitude; 10 sign-magnitude -> two's-complement; 11 absolute value (two's-complement in and out).
REQ-015 Mode 01: non-negative input unchanged; negative input -> {1'b1, magnitude}; input 1000..0 -> 1111..1 (max-magnitude negative), out_ovf=1.
REQ-016 Mode 10: sign bit 0 unchanged; sign bit 1 -> two's-complement negation of the magnitude; negative zero 1000..0 -> 0000..0, out_ovf=0.
REQ-017 Mode 11: negative -> negation; 1000..0 -> 0111..1, out_ovf=1.
REQ-018 Mode 00 and all non-saturating cases SHALL give out_ovf=0.
REQ-019 SHALL be a 2-stage pipeline: stage 1 registers mode/data and decode (sign, special-value detect); stage 2 registers result and out_ovf.
REQ-020 Latency SHALL be exactly 2 cycles from input handshake (in_valid & in_ready) to out_valid when out_ready held high.
REQ-021 Throughput SHALL be one word per cycle with out_ready high.
REQ-022 Each stage SHALL advance when it is empty or its successor advances in the same cycle; in_ready = !s1_valid | s1_advances (combinational path from out_ready allowed).
REQ-023 While out_valid & !out_ready, out_data/out_ovf SHALL hold stable; no word lost or duplicated; pipeline fills to 2 words then deasserts in_ready.
REQ-024 Simultaneous accept at input and release at output on a full pipe SHALL proceed without a bubble.
REQ-025 in_data/in_mode when in_valid=0 SHALL have no effect.

Reset
REQ-026 While rst_n=0 at a clk edge: s1/s2 valid flags, out_valid, out_ovf cleared; out_data = 0; ovf_count = 0.
REQ-027 in_ready SHALL be 1 in the first cycle after reset release.
REQ-028 Reset mid-operation SHALL discard all in-flight words; no out_valid for them after release.

Configuration
REQ-029 Macro SIGN_CONV_OVF_CNT_EN SHALL gate the overflow counter.
REQ-030 With macro: ovf_count increments by 1 on each output handshake with out_ovf=1, saturates at all-ones, never wraps.
REQ-031 Without macro: port ovf_count and counter logic absent; all other behaviour identical.

Structure
REQ-032 Package sign_conv_pkg SHALL hold the mode typedef (MODE_PASS, MODE_TC2SM, MODE_SM2TC, MODE_ABS) and WIDTH range constants.
REQ-033 Conversion arithmetic SHALL be one combinational sub-module sign_conv_core (mode, data -> result, ovf); pipeline/handshake in the top.

Verification (WIDTH=8, out_ready=1 unless stated)
REQ-034 Mode 01: 0xF5 -> 0x8B ovf=0; 0x75 -> 0x75; 0x80 -> 0xFF ovf=1; each 2 cycles after accept.
REQ-035 Mode 10: 0x85 -> 0xFB; 0xB5 -> 0xCB; 0x80 -> 0x00 ovf=0; 0x55 -> 0x55.
REQ-036 Mode 11: 0xE6 -> 0x1A; 0x80 -> 0x7F ovf=1; mode 00: 0xB4 -> 0xB4.
REQ-037 Back-to-back 13 words with out_ready low cycles 3-6: in_ready low after 2 accepts, outputs in order, stable during stall, none lost.
REQ-038 Reset asserted with 2 words in flight: after release out_valid=0, in_ready=1, ovf_count=0.
REQ-039 With SIGN_CONV_OVF_CNT_EN, OVF_CNT_W=4: 20 saturating words -> ovf_count = 0xF, held.

Source files
------------

// File: rtl/sign_conv_pkg.sv
// sign_conv_pkg: conversion mode encoding and legal data-width range for sign_converter_pipe.
package sign_conv_pkg;
  localparam int WIDTH_MIN = 4;
  localparam int WIDTH_MAX = 32;
  typedef enum logic [1:0] {
    MODE_PASS  = 2'b00,
    MODE_TC2SM = 2'b01,
    MODE_SM2TC = 2'b10,
    MODE_ABS   = 2'b11
  } mode_e;
endpackage

// File: rtl/sign_conv_core.sv
// sign_conv_core: combinational sign conversion (pass, tc->sm, sm->tc, abs) with saturation flag.
module sign_conv_core
  import sign_conv_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [1:0]       i_mode,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_sign,
  input  logic             i_min,
  output logic [WIDTH-1:0] o_data,
  output logic             o_ovf
);
  mode_e            w_mode;
  logic [WIDTH-1:0] w_neg;
  logic [WIDTH-1:0] w_mag_neg;
  assign w_mode    = mode_e'(i_mode);
  assign w_neg     = -i_data;
  assign w_mag_neg = -{1'b0, i_data[WIDTH-2:0]};
  // i_min is the lone two's-complement value whose magnitude does not fit
  assign o_ovf     = i_min & (w_mode == MODE_TC2SM | w_mode == MODE_ABS);
  always_comb begin
    o_data = !i_sign                ? i_data :
             w_mode == MODE_TC2SM   ? (i_min ? '1 : {1'b1, w_neg[WIDTH-2:0]}) :
             w_mode == MODE_SM2TC   ? w_mag_neg :
             w_mode == MODE_ABS     ? (i_min ? {1'b0, {(WIDTH-1){1'b1}}} : w_neg) :
                                      i_data;
  end
endmodule

// File: rtl/sign_converter_pipe.sv
// sign_converter_pipe: 2-stage valid/ready sign converter; stage 1 decodes, stage 2 holds result.
// Define SIGN_CONV_OVF_CNT_EN to add the saturating ovf_count output.
module sign_converter_pipe
  import sign_conv_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int OVF_CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_mode,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf
`ifdef SIGN_CONV_OVF_CNT_EN
  ,
  output logic [OVF_CNT_W-1:0] ovf_count
`endif
);
  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX || OVF_CNT_W < 1) begin : g_bad_cfg
    $error("sign_converter_pipe: WIDTH or OVF_CNT_W out of range");
  end
  logic             r_s1_valid;
  logic [1:0]       r_s1_mode;
  logic [WIDTH-1:0] r_s1_data;
  logic             r_s1_sign;
  logic             r_s1_min;
  logic             r_s2_valid;
  logic [WIDTH-1:0] r_s2_data;
  logic             r_s2_ovf;
  logic             w_s2_load;
  logic             w_s1_adv;
  logic [WIDTH-1:0] w_res;
  logic             w_ovf;
  assign w_s2_load = !r_s2_valid | out_ready;
  assign w_s1_adv  = r_s1_valid & w_s2_load;
  assign in_ready  = !r_s1_valid | w_s1_adv;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_mode  <= '0;
      r_s1_data  <= '0;
      r_s1_sign  <= 1'b0;
      r_s1_min   <= 1'b0;
    end else if (in_ready) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_mode <= in_mode;
        r_s1_data <= in_data;
        r_s1_sign <= in_data[WIDTH-1];
        r_s1_min  <= in_data == {1'b1, {(WIDTH-1){1'b0}}};
      end
    end
  end
  sign_conv_core #(.WIDTH(WIDTH)) u_core (
    .i_mode (r_s1_mode),
    .i_data (r_s1_data),
    .i_sign (r_s1_sign),
    .i_min  (r_s1_min),
    .o_data (w_res),
    .o_ovf  (w_ovf)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_data  <= '0;
      r_s2_ovf   <= 1'b0;
    end else if (w_s2_load) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_data <= w_res;
        r_s2_ovf  <= w_ovf;
      end
    end
  end
  assign out_valid = r_s2_valid;
  assign out_data  = r_s2_data;
  assign out_ovf   = r_s2_ovf;
`ifdef SIGN_CONV_OVF_CNT_EN
  logic [OVF_CNT_W-1:0] r_ovf_count;
  always_ff @(posedge clk) begin
    if (!rst_n) r_ovf_count <= '0;
    else if (r_s2_valid & out_ready & r_s2_ovf & ~&r_ovf_count) r_ovf_count <= r_ovf_count + 1'b1;
  end
  assign ovf_count = r_ovf_count;
`endif
endmodule

// File: tb/tb_sign_converter_pipe.sv
// tb_sign_converter_pipe: directed checks of conversion modes, latency, stall, reset and overflow count.
module tb_sign_converter_pipe;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_mode;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_ovf;
`ifdef SIGN_CONV_OVF_CNT_EN
  logic [3:0] ovf_count;
`endif
  int n_chk = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  sign_converter_pipe #(.WIDTH(8), .OVF_CNT_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf)
`ifdef SIGN_CONV_OVF_CNT_EN
    ,
    .ovf_count (ovf_count)
`endif
  );
  task automatic chk(input string t, input logic ok, input logic [31:0] o, input logic [31:0] e);
    n_chk++;
    if (ok !== 1'b1) begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", t, o, e);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send_one(input string tag, input logic [1:0] m, input logic [7:0] d,
                          input logic [7:0] e, input logic o);
    in_valid = 1'b1;
    in_mode  = m;
    in_data  = d;
    #1;
    chk({tag, "_in_ready"}, in_ready === 1'b1, in_ready, 1);
    tick();
    in_valid = 1'b0;
    in_mode  = 2'($urandom);
    in_data  = 8'($urandom);
    chk({tag, "_lat1_valid"}, out_valid === 1'b0, out_valid, 0);
    tick();
    chk({tag, "_valid"}, out_valid === 1'b1, out_valid, 1);
    chk({tag, "_data"}, out_data === e, out_data, e);
    chk({tag, "_ovf"}, out_ovf === o, out_ovf, o);
    tick();
  endtask
  logic [7:0] sv_d [13] = '{8'h01, 8'hFF, 8'h10, 8'hF0, 8'h7F, 8'h81, 8'h80,
                            8'h33, 8'hCD, 8'h00, 8'h40, 8'hC0, 8'h90};
  logic [7:0] sv_e [13] = '{8'h01, 8'h01, 8'h10, 8'h10, 8'h7F, 8'h7F, 8'h7F,
                            8'h33, 8'h33, 8'h00, 8'h40, 8'h40, 8'h70};
  initial begin
    int sent, recv;
    logic held_v, held_o;
    logic [7:0] held_d;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_mode = 2'b00;
    in_data = 8'h00;
    out_ready = 1'b1;
    tick();
    tick();
    chk("rst_out_valid", out_valid === 1'b0, out_valid, 0);
    chk("rst_out_data", out_data === 8'h00, out_data, 0);
    chk("rst_out_ovf", out_ovf === 1'b0, out_ovf, 0);
    rst_n = 1'b1;
    #1;
    chk("rst_rel_in_ready", in_ready === 1'b1, in_ready, 1);
    send_one("tc2sm_f5", 2'b01, 8'hF5, 8'h8B, 1'b0);
    send_one("tc2sm_75", 2'b01, 8'h75, 8'h75, 1'b0);
    send_one("tc2sm_80", 2'b01, 8'h80, 8'hFF, 1'b1);
    send_one("sm2tc_85", 2'b10, 8'h85, 8'hFB, 1'b0);
    send_one("sm2tc_b5", 2'b10, 8'hB5, 8'hCB, 1'b0);
    send_one("sm2tc_80", 2'b10, 8'h80, 8'h00, 1'b0);
    send_one("sm2tc_55", 2'b10, 8'h55, 8'h55, 1'b0);
    send_one("abs_e6", 2'b11, 8'hE6, 8'h1A, 1'b0);
    send_one("abs_80", 2'b11, 8'h80, 8'h7F, 1'b1);
    send_one("pass_b4", 2'b00, 8'hB4, 8'hB4, 1'b0);
    send_one("pass_80", 2'b00, 8'h80, 8'h80, 1'b0);
    sent = 0;
    recv = 0;
    held_v = 1'b0;
    held_o = 1'b0;
    held_d = 8'h00;
    for (int c = 0; c < 40 && recv < 13; c++) begin
      out_ready = !(c >= 3 && c <= 6);
      in_valid  = sent < 13;
      in_mode   = 2'b11;
      in_data   = sent < 13 ? sv_d[sent] : 8'h00;
      #1;
      if (c >= 3 && c <= 6) chk("stall_in_ready", in_ready === 1'b0, in_ready, 0);
      if (held_v) begin
        chk("stall_data_stable", out_data === held_d, out_data, held_d);
        chk("stall_ovf_stable", out_ovf === held_o, out_ovf, held_o);
      end
      if (out_valid && out_ready) begin
        chk("stream_data", out_data === sv_e[recv], out_data, sv_e[recv]);
        chk("stream_ovf", out_ovf === (sv_d[recv] == 8'h80), out_ovf, sv_d[recv] == 8'h80);
        recv++;
      end
      held_v = out_valid && !out_ready;
      held_d = out_data;
      held_o = out_ovf;
      if (in_valid && in_ready) sent++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("stream_count", recv == 13, recv, 13);
    tick();
    chk("stream_drained", out_valid === 1'b0, out_valid, 0);
`ifdef SIGN_CONV_OVF_CNT_EN
    chk("ovf_count_3", ovf_count === 4'h3, ovf_count, 3);
`endif
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_mode = 2'b01;
    in_data = 8'h80;
    tick();
    in_data = 8'h81;
    tick();
    in_valid = 1'b0;
    chk("full_out_valid", out_valid === 1'b1, out_valid, 1);
    chk("full_in_ready", in_ready === 1'b0, in_ready, 0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid === 1'b0, out_valid, 0);
    chk("midrst_out_data", out_data === 8'h00, out_data, 0);
    chk("midrst_in_ready", in_ready === 1'b1, in_ready, 1);
`ifdef SIGN_CONV_OVF_CNT_EN
    chk("midrst_ovf_count", ovf_count === 4'h0, ovf_count, 0);
`endif
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("midrst_no_ghost", out_valid === 1'b0, out_valid, 0);
    end
    sent = 0;
    recv = 0;
    for (int c = 0; c < 40 && recv < 20; c++) begin
      in_valid = sent < 20;
      in_mode = 2'b01;
      in_data = 8'h80;
      #1;
      if (out_valid) begin
        chk("sat_data", out_data === 8'hFF, out_data, 8'hFF);
        chk("sat_ovf", out_ovf === 1'b1, out_ovf, 1);
        recv++;
      end
      if (in_valid && in_ready) sent++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk("sat_count", recv == 20, recv, 20);
`ifdef SIGN_CONV_OVF_CNT_EN
    chk("ovf_count_sat", ovf_count === 4'hF, ovf_count, 4'hF);
`endif
    send_one("sat_extra", 2'b11, 8'h80, 8'h7F, 1'b1);
`ifdef SIGN_CONV_OVF_CNT_EN
    chk("ovf_count_held", ovf_count === 4'hF, ovf_count, 4'hF);
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
